// File: rtl/fpga_pkg.sv
// fpga_pkg: shared types and helpers for the two-master memory arbiter slice.
//   - core-side and memory-side AXI4 request/response structs
//   - arb_sel_t: one-bit master select; ARB_SEL_BIT: position of the select
//     tag inside the memory-side ID
//   - ax_to_mem(): widens a core address-channel beat to the memory ID space
package fpga_pkg;

  localparam int unsigned CORE_ID_WIDTH = 8;
  localparam int unsigned MEM_ID_WIDTH  = 9;
  localparam int unsigned ADDR_WIDTH    = 32;
  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned ARB_SEL_BIT   = 8;

  typedef logic arb_sel_t;
  typedef logic [CORE_ID_WIDTH-1:0] core_id_t;
  typedef logic [MEM_ID_WIDTH-1:0]  mem_id_t;

  typedef struct packed {
    core_id_t              id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } core_ax_t;

  typedef struct packed {
    mem_id_t               id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } mem_ax_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic                    last;
  } axi_w_t;

  typedef struct packed {
    core_id_t   id;
    logic [1:0] resp;
  } core_b_t;

  typedef struct packed {
    mem_id_t    id;
    logic [1:0] resp;
  } mem_b_t;

  typedef struct packed {
    core_id_t              id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } core_r_t;

  typedef struct packed {
    mem_id_t               id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } mem_r_t;

  typedef struct packed {
    core_ax_t aw;
    logic     aw_valid;
    axi_w_t   w;
    logic     w_valid;
    logic     b_ready;
    core_ax_t ar;
    logic     ar_valid;
    logic     r_ready;
  } core_axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    core_b_t b;
    logic    b_valid;
    logic    ar_ready;
    core_r_t r;
    logic    r_valid;
  } core_axi_resp_t;

  typedef struct packed {
    mem_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    mem_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mem_axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    mem_b_t  b;
    logic    b_valid;
    logic    ar_ready;
    mem_r_t  r;
    logic    r_valid;
  } mem_axi_resp_t;

  // Memory ID = zero-extended {sel, core id}; sel lands on ARB_SEL_BIT.
  function automatic mem_id_t mk_mem_id(arb_sel_t sel, core_id_t id);
    return mem_id_t'({sel, id});
  endfunction

  function automatic mem_ax_t ax_to_mem(arb_sel_t sel, core_ax_t ax);
    mem_ax_t m;
    m.id    = mk_mem_id(sel, ax.id);
    m.addr  = ax.addr;
    m.len   = ax.len;
    m.size  = ax.size;
    m.burst = ax.burst;
    return m;
  endfunction

endpackage

// File: rtl/fpga_mem_arb_rr.sv
// fpga_mem_arb_rr: two-input round-robin lock arbiter for one AXI address
// channel. Once a grant is shown without a handshake it is frozen until the
// handshake happens, so the granted payload stays stable.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   valid_i[1:0]  : per-master request valid
//   ready_i       : downstream ready
//   valid_o       : downstream valid
//   gnt_o         : selected master
//   hs_o          : handshake this cycle
module fpga_mem_arb_rr
  import fpga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] valid_i,
  input  logic       ready_i,
  output logic       valid_o,
  output arb_sel_t   gnt_o,
  output logic       hs_o
);

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  arb_state_e state_q, state_d;
  arb_sel_t   ptr_q, ptr_d;
  arb_sel_t   gnt_q, gnt_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gnt_o   = gnt_q;
    valid_o = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (&valid_i) gnt_o = ptr_q;
        else          gnt_o = valid_i[1];
        valid_o = |valid_i;
      end
      ARB_LOCKED: begin
        gnt_o   = gnt_q;
        valid_o = valid_i[gnt_q];
      end
      default: ;
    endcase
    hs_o = valid_o & ready_i;
    if (hs_o) begin
      state_d = ARB_IDLE;
      ptr_d   = ~gnt_o;
    end else if (valid_o) begin
      state_d = ARB_LOCKED;
      gnt_d   = gnt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

endmodule

// File: rtl/fpga_mem_arbiter.sv
// fpga_mem_arbiter: shares one AXI4 memory port between two core masters.
// AW and AR are round-robin arbitrated independently; W follows AW grant
// order through a small order FIFO; B/R are routed by ID bit ARB_SEL_BIT.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   s_req_i/s_resp_o: core-side request/response, master 0/1
//   m_req_o/m_resp_i: memory-side request/response
//   perf_aw_cnt_o   : AW handshakes per master
//   perf_ar_cnt_o   : AR handshakes per master
// Optional: define FPGA_MEM_ARB_PERF_EN to build the handshake counters;
// otherwise the perf outputs are tied to zero.
module fpga_mem_arbiter
  import fpga_pkg::*;
#(
  parameter int unsigned WFifoDepth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  core_axi_req_t  [1:0]     s_req_i,
  output core_axi_resp_t [1:0]     s_resp_o,
  output mem_axi_req_t             m_req_o,
  input  mem_axi_resp_t            m_resp_i,
  output logic           [1:0][31:0] perf_aw_cnt_o,
  output logic           [1:0][31:0] perf_ar_cnt_o
);

  localparam int unsigned PtrW = $clog2(WFifoDepth);

  if (MEM_ID_WIDTH < 9 || WFifoDepth < 2 || (WFifoDepth & (WFifoDepth - 1)) != 0)
  begin : g_param_check
    $error("fpga_mem_arbiter: MEM_ID_WIDTH must be >= 9 and WFifoDepth a power of two >= 2");
  end

  logic            fifo_full, fifo_empty;
  logic [1:0]      aw_req, ar_req;
  logic            aw_valid, aw_hs, ar_valid, ar_hs;
  arb_sel_t        aw_gnt, ar_gnt, w_src, b_sel, r_sel;
  logic            w_valid, w_last_hs, do_push, do_pop;

  arb_sel_t        fifo_q [WFifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;

  assign fifo_full  = (cnt_q == (PtrW+1)'(WFifoDepth));
  assign fifo_empty = (cnt_q == '0);

  assign aw_req = {s_req_i[1].aw_valid, s_req_i[0].aw_valid} & {2{rst_ni & ~fifo_full}};
  assign ar_req = {s_req_i[1].ar_valid, s_req_i[0].ar_valid} & {2{rst_ni}};

  fpga_mem_arb_rr u_aw_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (aw_req),
    .ready_i (m_resp_i.aw_ready),
    .valid_o (aw_valid),
    .gnt_o   (aw_gnt),
    .hs_o    (aw_hs)
  );

  fpga_mem_arb_rr u_ar_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (ar_req),
    .ready_i (m_resp_i.ar_ready),
    .valid_o (ar_valid),
    .gnt_o   (ar_gnt),
    .hs_o    (ar_hs)
  );

  // Empty FIFO: W follows the current AW grant so slaves that want WVALID
  // before AWREADY cannot deadlock. An AW and last-W handshake together on
  // an empty FIFO consume that bypass slot and leave the FIFO untouched.
  assign w_src     = fifo_empty ? aw_gnt : fifo_q[rd_ptr_q];
  assign w_valid   = s_req_i[w_src].w_valid & rst_ni;
  assign w_last_hs = w_valid & m_resp_i.w_ready & s_req_i[w_src].w.last;
  assign do_push   = aw_hs & ~(fifo_empty & w_last_hs);
  assign do_pop    = w_last_hs & ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (PtrW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) fifo_q[wr_ptr_q] <= aw_gnt;
  end

  assign b_sel = m_resp_i.b.id[ARB_SEL_BIT];
  assign r_sel = m_resp_i.r.id[ARB_SEL_BIT];

  always_comb begin
    m_req_o  = '0;
    s_resp_o = '0;

    m_req_o.aw       = ax_to_mem(aw_gnt, s_req_i[aw_gnt].aw);
    m_req_o.aw_valid = aw_valid;
    m_req_o.w        = s_req_i[w_src].w;
    m_req_o.w_valid  = w_valid;
    m_req_o.ar       = ax_to_mem(ar_gnt, s_req_i[ar_gnt].ar);
    m_req_o.ar_valid = ar_valid;
    m_req_o.b_ready  = s_req_i[b_sel].b_ready & rst_ni;
    m_req_o.r_ready  = s_req_i[r_sel].r_ready & rst_ni;

    for (int unsigned i = 0; i < 2; i++) begin
      s_resp_o[i].b.id   = m_resp_i.b.id[CORE_ID_WIDTH-1:0];
      s_resp_o[i].b.resp = m_resp_i.b.resp;
      s_resp_o[i].r.id   = m_resp_i.r.id[CORE_ID_WIDTH-1:0];
      s_resp_o[i].r.data = m_resp_i.r.data;
      s_resp_o[i].r.resp = m_resp_i.r.resp;
      s_resp_o[i].r.last = m_resp_i.r.last;
    end

    s_resp_o[aw_gnt].aw_ready = m_resp_i.aw_ready & ~fifo_full & rst_ni;
    s_resp_o[w_src].w_ready   = m_resp_i.w_ready & rst_ni;
    s_resp_o[ar_gnt].ar_ready = m_resp_i.ar_ready & rst_ni;
    s_resp_o[b_sel].b_valid   = m_resp_i.b_valid & rst_ni;
    s_resp_o[r_sel].r_valid   = m_resp_i.r_valid & rst_ni;
  end

`ifdef FPGA_MEM_ARB_PERF_EN
  logic [1:0][31:0] aw_cnt_q, ar_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_cnt_q <= '0;
      ar_cnt_q <= '0;
    end else begin
      if (aw_hs) aw_cnt_q[aw_gnt] <= aw_cnt_q[aw_gnt] + 32'd1;
      if (ar_hs) ar_cnt_q[ar_gnt] <= ar_cnt_q[ar_gnt] + 32'd1;
    end
  end

  assign perf_aw_cnt_o = aw_cnt_q;
  assign perf_ar_cnt_o = ar_cnt_q;
`else
  assign perf_aw_cnt_o = '0;
  assign perf_ar_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpga_mem_arbiter.sv
// tb_fpga_mem_arbiter: directed self-checking bench for fpga_mem_arbiter.
module tb_fpga_mem_arbiter;
  import fpga_pkg::*;

  logic                  clk;
  logic                  rst_n;
  core_axi_req_t  [1:0]  s_req;
  core_axi_resp_t [1:0]  s_resp;
  mem_axi_req_t          m_req;
  mem_axi_resp_t         m_resp;
  logic [1:0][31:0]      perf_aw, perf_ar;

  int checks = 0;
  int errors = 0;

  fpga_mem_arbiter #(.WFifoDepth(4)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .s_req_i       (s_req),
    .s_resp_o      (s_resp),
    .m_req_o       (m_req),
    .m_resp_i      (m_resp),
    .perf_aw_cnt_o (perf_aw),
    .perf_ar_cnt_o (perf_ar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_req  = '0;
    m_resp = '0;
    rst_n  = 1'b0;
    tick();
    rst_n  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_req[0].aw_valid = 1'b1; s_req[1].aw_valid = 1'b1;
    s_req[0].ar_valid = 1'b1; s_req[1].ar_valid = 1'b1;
    s_req[0].w_valid  = 1'b1; s_req[1].w_valid  = 1'b1;
    m_resp.aw_ready = 1'b1; m_resp.w_ready = 1'b1; m_resp.ar_ready = 1'b1;
    m_resp.b_valid  = 1'b1; m_resp.r_valid = 1'b1;
    tick();
    #1;
    checks++;
    if ({m_req.aw_valid, m_req.w_valid, m_req.ar_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_m_valids: aw/w/ar valid=%b required 000",
               {m_req.aw_valid, m_req.w_valid, m_req.ar_valid});
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({s_resp[i].aw_ready, s_resp[i].w_ready, s_resp[i].ar_ready,
           s_resp[i].b_valid, s_resp[i].r_valid} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_s_resp[%0d]: aw_rdy/w_rdy/ar_rdy/b_vld/r_vld=%b required 00000", i,
                 {s_resp[i].aw_ready, s_resp[i].w_ready, s_resp[i].ar_ready,
                  s_resp[i].b_valid, s_resp[i].r_valid});
      end
    end
    do_reset();
    checks++;
    if (perf_aw !== '0 || perf_ar !== '0) begin
      errors++;
      $display("FAIL reset_perf: aw=%h ar=%h required 0", perf_aw, perf_ar);
    end
  endtask

  task automatic test_ar_round_robin();
    logic [8:0] exp_id;
    int         g;
    do_reset();
    m_resp.ar_ready = 1'b1;
    s_req[0].ar.id = 8'h05; s_req[0].ar.addr = 32'h0000_1000; s_req[0].ar_valid = 1'b1;
    s_req[1].ar.id = 8'h05; s_req[1].ar.addr = 32'h0000_2000; s_req[1].ar_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      g      = k % 2;
      exp_id = (g == 1) ? 9'h105 : 9'h005;
      checks++;
      if (m_req.ar_valid !== 1'b1 || m_req.ar.id !== exp_id ||
          m_req.ar.addr !== ((g == 1) ? 32'h0000_2000 : 32'h0000_1000)) begin
        errors++;
        $display("FAIL ar_rr_id cycle %0d: valid=%b id=%h addr=%h required valid=1 id=%h", k,
                 m_req.ar_valid, m_req.ar.id, m_req.ar.addr, exp_id);
      end
      checks++;
      if (s_resp[g].ar_ready !== 1'b1 || s_resp[1-g].ar_ready !== 1'b0) begin
        errors++;
        $display("FAIL ar_rr_ready cycle %0d: m0=%b m1=%b required granted=%0d only", k,
                 s_resp[0].ar_ready, s_resp[1].ar_ready, g);
      end
      tick();
    end
    s_req = '0;
  endtask

  task automatic test_aw_lock();
    logic       exp_g;
    logic [8:0] exp_id;
    do_reset();
    s_req[0].aw.id = 8'h11; s_req[1].aw.id = 8'h22;
    for (int c = 0; c < 5; c++) begin
      s_req[0].aw_valid = (c <= 3);
      s_req[1].aw_valid = (c >= 1);
      m_resp.aw_ready   = (c >= 3);
      #1;
      exp_g  = (c >= 4);
      exp_id = exp_g ? 9'h122 : 9'h011;
      checks++;
      if (m_req.aw_valid !== 1'b1 || m_req.aw.id !== exp_id) begin
        errors++;
        $display("FAIL aw_lock_grant cycle %0d: valid=%b id=%h required valid=1 id=%h", c,
                 m_req.aw_valid, m_req.aw.id, exp_id);
      end
      checks++;
      if (s_resp[exp_g].aw_ready !== (c >= 3) || s_resp[~exp_g].aw_ready !== 1'b0) begin
        errors++;
        $display("FAIL aw_lock_ready cycle %0d: m0=%b m1=%b required granted=%0d ready=%b", c,
                 s_resp[0].aw_ready, s_resp[1].aw_ready, exp_g, (c >= 3));
      end
      tick();
    end
    s_req = '0;
  endtask

  task automatic test_w_order();
    do_reset();
    m_resp.aw_ready = 1'b1; m_resp.w_ready = 1'b1;
    s_req[0].aw.len = 8'd3; s_req[1].aw.len = 8'd1;
    s_req[0].aw_valid = 1'b1; s_req[1].aw_valid = 1'b1;
    s_req[1].w_valid = 1'b1; s_req[1].w.data = 32'hB0; s_req[1].w.last = 1'b0;
    #1;
    checks++;
    if (m_req.aw.id[8] !== 1'b0 || s_resp[1].w_ready !== 1'b0 || m_req.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL w_order_c0: aw_sel=%b m1_wready=%b w_valid=%b required 0 0 0",
               m_req.aw.id[8], s_resp[1].w_ready, m_req.w_valid);
    end
    tick();
    s_req[0].aw_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 1) s_req[1].aw_valid = 1'b0;
      s_req[0].w_valid = 1'b1;
      s_req[0].w.data  = 32'hA0 + b;
      s_req[0].w.last  = (b == 3);
      #1;
      checks++;
      if (s_resp[0].w_ready !== 1'b1 || s_resp[1].w_ready !== 1'b0 ||
          m_req.w.data !== 32'hA0 + b || m_req.w.last !== (b == 3)) begin
        errors++;
        $display("FAIL w_order_m0 beat %0d: m0_rdy=%b m1_rdy=%b data=%h last=%b required 1 0 %h %b",
                 b, s_resp[0].w_ready, s_resp[1].w_ready, m_req.w.data, m_req.w.last,
                 32'hA0 + b, (b == 3));
      end
      tick();
    end
    s_req[0].w_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_req[1].w.data = 32'hB0 + b;
      s_req[1].w.last = (b == 1);
      #1;
      checks++;
      if (s_resp[1].w_ready !== 1'b1 || m_req.w_valid !== 1'b1 || m_req.w.data !== 32'hB0 + b) begin
        errors++;
        $display("FAIL w_order_m1 beat %0d: m1_rdy=%b w_valid=%b data=%h required 1 1 %h",
                 b, s_resp[1].w_ready, m_req.w_valid, m_req.w.data, 32'hB0 + b);
      end
      tick();
    end
    s_req = '0;
    #1;
    checks++;
    if (m_req.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL w_order_idle: w_valid=%b required 0", m_req.w_valid);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_resp.aw_ready = 1'b1; m_resp.w_ready = 1'b1;
    s_req[0].aw_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (m_req.aw_valid !== 1'b1 || s_resp[0].aw_ready !== 1'b1) begin
        errors++;
        $display("FAIL fifo_fill cycle %0d: aw_valid=%b aw_ready=%b required 1 1", c,
                 m_req.aw_valid, s_resp[0].aw_ready);
      end
      tick();
    end
    s_req[0].w_valid = 1'b1; s_req[0].w.last = 1'b1;
    #1;
    checks++;
    if (m_req.aw_valid !== 1'b0 || s_resp[0].aw_ready !== 1'b0 || s_resp[0].w_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full_block: aw_valid=%b aw_ready=%b w_ready=%b required 0 0 1",
               m_req.aw_valid, s_resp[0].aw_ready, s_resp[0].w_ready);
    end
    tick();
    s_req[0].w_valid = 1'b0;
    #1;
    checks++;
    if (m_req.aw_valid !== 1'b1 || s_resp[0].aw_ready !== 1'b1) begin
      errors++;
      $display("FAIL fifo_after_pop: aw_valid=%b aw_ready=%b required 1 1",
               m_req.aw_valid, s_resp[0].aw_ready);
    end
    tick();
    s_req = '0;
  endtask

  task automatic test_bypass();
    do_reset();
    m_resp.aw_ready = 1'b1; m_resp.w_ready = 1'b1;
    s_req[1].aw_valid = 1'b1; s_req[1].w_valid = 1'b1; s_req[1].w.last = 1'b1;
    #1;
    checks++;
    if (s_resp[1].aw_ready !== 1'b1 || s_resp[1].w_ready !== 1'b1 || m_req.w_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass_m1: aw_ready=%b w_ready=%b w_valid=%b required 1 1 1",
               s_resp[1].aw_ready, s_resp[1].w_ready, m_req.w_valid);
    end
    tick();
    s_req = '0;
    s_req[0].w_valid = 1'b1; s_req[0].w.last = 1'b1;
    #1;
    checks++;
    if (s_resp[0].w_ready !== 1'b1 || s_resp[1].w_ready !== 1'b0) begin
      errors++;
      $display("FAIL bypass_no_push: m0_wready=%b m1_wready=%b required 1 0",
               s_resp[0].w_ready, s_resp[1].w_ready);
    end
    tick();
    s_req = '0;
  endtask

  task automatic test_resp_route();
    do_reset();
    m_resp.r_valid = 1'b1; m_resp.r.id = 9'h1AB; m_resp.r.data = 32'hCAFE_0001;
    s_req[1].r_ready = 1'b1; s_req[0].r_ready = 1'b0;
    #1;
    checks++;
    if (s_resp[1].r_valid !== 1'b1 || s_resp[1].r.id !== 8'hAB ||
        s_resp[1].r.data !== 32'hCAFE_0001 || s_resp[0].r_valid !== 1'b0) begin
      errors++;
      $display("FAIL r_route: m1 vld=%b id=%h data=%h m0 vld=%b required 1 ab cafe0001 0",
               s_resp[1].r_valid, s_resp[1].r.id, s_resp[1].r.data, s_resp[0].r_valid);
    end
    checks++;
    if (m_req.r_ready !== 1'b1) begin
      errors++;
      $display("FAIL r_ready_fwd: r_ready=%b required 1", m_req.r_ready);
    end
    s_req[1].r_ready = 1'b0; s_req[0].r_ready = 1'b1;
    #1;
    checks++;
    if (m_req.r_ready !== 1'b0) begin
      errors++;
      $display("FAIL r_ready_sel: r_ready=%b required 0", m_req.r_ready);
    end
    m_resp.b_valid = 1'b1; m_resp.b.id = 9'h012; m_resp.b.resp = 2'b10;
    s_req[0].b_ready = 1'b1; s_req[1].b_ready = 1'b0;
    #1;
    checks++;
    if (s_resp[0].b_valid !== 1'b1 || s_resp[0].b.id !== 8'h12 || s_resp[0].b.resp !== 2'b10 ||
        s_resp[1].b_valid !== 1'b0 || m_req.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_route: m0 vld=%b id=%h resp=%b m1 vld=%b b_ready=%b required 1 12 10 0 1",
               s_resp[0].b_valid, s_resp[0].b.id, s_resp[0].b.resp, s_resp[1].b_valid,
               m_req.b_ready);
    end
    tick();
    m_resp = '0;
    s_req  = '0;
  endtask

  task automatic test_perf();
    logic [1:0][31:0] exp_ar;
    do_reset();
    m_resp.ar_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      s_req[0].ar_valid = (c < 3);
      s_req[1].ar_valid = (c >= 3);
      tick();
    end
    s_req = '0;
    #1;
`ifdef FPGA_MEM_ARB_PERF_EN
    exp_ar[1] = 32'd2;
    exp_ar[0] = 32'd3;
`else
    exp_ar = '0;
`endif
    checks++;
    if (perf_ar !== exp_ar || perf_aw !== '0) begin
      errors++;
      $display("FAIL perf_cnt: ar={%0d,%0d} aw={%0d,%0d} required ar={%0d,%0d} aw={0,0}",
               perf_ar[1], perf_ar[0], perf_aw[1], perf_aw[0], exp_ar[1], exp_ar[0]);
    end
  endtask

  initial begin
    s_req  = '0;
    m_resp = '0;
    rst_n  = 1'b0;
    test_reset();
    test_ar_round_robin();
    test_aw_lock();
    test_w_order();
    test_fifo_full();
    test_bypass();
    test_resp_route();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_mem_arbiter.md
# fpga_mem_arbiter

Two-master to one-slave AXI4 arbiter sharing the single memory port between two core-side masters. Sits between the two `core_axi` request/response pairs and the `mem_axi` port toward the memory controller. Round-robin arbitration on AW and AR independently, W ordering by AW grant order, B/R routed back by an ID tag bit prepended to the master ID.

## Interface
- `WFifoDepth`, 4: W-order FIFO entries, i.e. maximum outstanding AW grants whose write data burst is not yet complete; power of two, ≥2.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `s_req_i`  in  2×`core_axi_req_t`  requests from master 0/1.
- `s_resp_o`  out  2×`core_axi_resp_t`  responses to master 0/1.
- `m_req_o`  out  `mem_axi_req_t`  request to memory.
- `m_resp_i`  in  `mem_axi_resp_t`  response from memory.
- `perf_aw_cnt_o`  out  2×32  AW handshakes per master (see Configuration).
- `perf_ar_cnt_o`  out  2×32  AR handshakes per master.

## Operation
- ID rule: `m.aw.id`/`m.ar.id` = zero-extended {sel, s.id[7:0]}; sel at bit 8. `MEM_ID_WIDTH` < 9 is an elaboration error.
- AW and AR each use one round-robin lock arbiter, states IDLE and LOCKED.
- IDLE: if exactly one master valid, grant it; if both, grant the one indicated by priority pointer. `m.*_valid` asserted same cycle. Handshake same cycle → stay IDLE, pointer moves to the other master. No handshake → LOCKED, grant frozen.
- LOCKED: grant fixed; other master's valid ignored; on handshake → IDLE, pointer moves to the other master.
- Ungranted master sees `*_ready` = 0. Granted master's `*_ready` = `m_resp_i.*_ready`.
- AW additionally blocked (`m.aw_valid` = 0, both aw_ready = 0) while W-order FIFO full.
- Each AW handshake pushes sel into W-order FIFO. W source = FIFO head; if FIFO empty, W source = currently granted AW master (bypass, avoids deadlock with slaves that wait for WVALID before AWREADY). Non-source master sees `w_ready` = 0. W handshake with `wlast` = 1 pops head (or consumes bypass entry when AW and last W handshake occur together with FIFO empty: no push).
- B and R: `s_resp_o[id[8]]` gets valid/payload, id truncated to 8 bits; `m.b_ready`/`m.r_ready` = that master's ready. Other master's b_valid/r_valid = 0.
- Simultaneous AW handshake and last-W pop: FIFO count unchanged; full check uses pre-pop count.

## Timing
- Zero-cycle latency on all channels: request/response paths combinational through arbiter; only grant state, pointer, FIFO, counters registered.
- Reset values: pointer = master 0, both arbiters IDLE, FIFO empty, counters 0; all `m_req_o` valids 0 and all `s_resp_o` valids/readies 0 while rst_ni low.
- Reset mid-burst: outstanding transactions abandoned, no draining; both sides must be reset together.
- Two back-to-back requests from same master with other idle: granted every cycle, no bubble.

## Configuration
- `FPGA_MEM_ARB_PERF_EN` defined: `perf_aw_cnt_o`/`perf_ar_cnt_o` count handshakes per master, wrap at 2^32.
- Undefined: counters not built, outputs tied to 0; ports kept so the interface is unchanged.

## Structure
- `fpga_pkg`: `arb_sel_t` (1 bit), `ARB_SEL_BIT` = 8, function building mem ID from sel and core ID.
- Sub-module `fpga_mem_arb_rr`: two-input round-robin lock arbiter (valid in, ready in, grant out, handshake), instantiated for AW and AR. W-order FIFO inline.

## Test plan
- Both masters assert AR id 0x05 every cycle, slave always ready → grants alternate 0,1,0,1; `m.ar.id` = 0x005, 0x105.
- Master 0 AW, slave `aw_ready` low 3 cycles, master 1 AW from cycle 1 → grant stays 0 through cycle 3, master 1 granted cycle 4.
- AW m0 (4 beats) then AW m1 (2 beats), W of m1 presented first → m1 W stalled until m0's 4th beat wlast handshake.
- WFifoDepth = 4, 4 AWs accepted, no W → 5th AW blocked; one wlast completes → 5th AW accepted next cycle.
- R with id 0x1AB → delivered to master 1 with id 0xAB; master 0 r_valid stays 0.
- With `FPGA_MEM_ARB_PERF_EN`, 3 AR m0 + 2 AR m1 → `perf_ar_cnt_o` = {2,3}; without macro → all 0.
